// File: rtl/stage3_mixer_if.sv
// Valid/ready bundle between stage-2, stage3_mixer and the output stage.
// The master modport is the side that drives words in and drains the head.
interface stage3_mixer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_state;
    logic [15:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_tag;

    modport master (
        output in_valid, in_data, in_state, key, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_state, key, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/stage3_mixer.sv
// Stage-3 keyed mixer: state-selected transform with rotating round index, FIFO buffered.
// Optional running XOR checksum is built only when STAGE3_CHECKSUM_EN is defined.
module stage3_mixer #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    stage3_mixer_if.slave bus,
    output logic [15:0]   checksum,
    output logic [7:0]    stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [1:0]   round;
    logic [19:0]  mem [DEPTH];
    logic [19:0]  head;
    logic [15:0]  t;
    logic         full;
    logic         empty;
    logic         accept;
    logic         drain;

    function automatic logic [15:0] rotl(input logic [15:0] d, input logic [1:0] r);
        logic [31:0] dd;
        logic [2:0]  amt;
        amt = {1'b0, r} + 3'd1;
        dd  = {d, d} << amt;
        return dd[31:16];
    endfunction

    function automatic logic [15:0] mix(input logic [15:0] d, input logic [1:0] s,
                                        input logic [15:0] k, input logic [1:0] r);
        logic [15:0] res;
        case (s)
            2'd0:    res = d ^ k;
            2'd1:    res = rotl(d, r);
            2'd2:    res = d + k;
            default: res = {d[7:0], d[15:8]} ^ ~k;
        endcase
        return res;
    endfunction

    // Full/empty from registered pointers only, so in_ready never depends on out_ready.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign accept = bus.in_valid && bus.in_ready;
    assign drain  = bus.out_valid && bus.out_ready;
    assign t      = mix(bus.in_data, bus.in_state, bus.key, round);

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign head          = mem[rd_ptr[AW-1:0]];
    assign bus.out_data  = head[19:4];
    assign bus.out_tag   = head[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            round     <= '0;
            stall_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr[AW-1:0]] <= {t, bus.in_state, round};
                wr_ptr              <= wr_ptr + PTR_ONE;
                round               <= round + 2'd1;
            end
            if (drain) rd_ptr <= rd_ptr + PTR_ONE;
            if (bus.in_valid && !bus.in_ready && stall_cnt != 8'hFF)
                stall_cnt <= stall_cnt + 8'd1;
        end
    end

`ifdef STAGE3_CHECKSUM_EN
    logic [15:0] csum;

    always_ff @(posedge clk) begin
        if (rst)         csum <= '0;
        else if (accept) csum <= csum ^ t;
    end

    assign checksum = csum;
`else
    assign checksum = 16'h0000;
`endif
endmodule

// File: tb/tb_stage3_mixer.sv
// Scoreboard bench for stage3_mixer: driver pushes hand-computed results, a negedge monitor pops on drain.
module tb_stage3_mixer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] checksum;
    logic [7:0]  stall_cnt;

    stage3_mixer_if bus ();

    stage3_mixer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .checksum  (checksum),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          drains = 0;
    logic [19:0] sb [$];
    logic [1:0]  exp_r = 2'd0;
    logic [15:0] csum_m = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: a drain happens at the next rising edge whenever valid&&ready here.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            drains++;
            if (sb.size() == 0) begin
                check("unexpected_output", {12'h0, bus.out_data, bus.out_tag}, 32'hFFFF_FFFF);
            end else begin
                logic [19:0] e;
                e = sb.pop_front();
                check("drain_word_tag", {12'h0, bus.out_data, bus.out_tag}, {12'h0, e});
            end
        end
    end

    function automatic logic [15:0] exp_csum();
`ifdef STAGE3_CHECKSUM_EN
        return csum_m;
`else
        return 16'h0000;
`endif
    endfunction

    // All driving happens 1 time unit after a rising edge.
    task automatic send(input logic [1:0] s, input logic [15:0] d, input logic [15:0] k,
                        input logic [15:0] exp_t);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_state = s;
        bus.in_data  = d;
        bus.key      = k;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            sb.push_back({exp_t, s, exp_r});
            exp_r  = exp_r + 2'd1;
            csum_m = csum_m ^ exp_t;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_r  = 2'd0;
        csum_m = 16'h0000;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_complete", {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int idx;
        int d0;
        int cnt;
        logic [15:0] fill_in  [5];
        logic [15:0] fill_out [5];
        fill_in  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        fill_out = '{16'h1E1E, 16'h2D2D, 16'h3C3C, 16'h4B4B, 16'h5A5A};

        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0;
        bus.in_state  = 2'd0;
        bus.key       = 16'h0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_checksum",  {16'd0, checksum}, 32'd0);
        check("rst_stall_cnt", {24'd0, stall_cnt}, 32'd0);
        check("rst_out_data",  {16'd0, bus.out_data}, 32'd0);
        check("rst_out_tag",   {28'd0, bus.out_tag}, 32'd0);

        // Single word, state 0
        send(2'd0, 16'h1234, 16'h00FF, 16'h12CB);
        check("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t1_out_data",  {16'd0, bus.out_data}, 32'h12CB);
        check("t1_out_tag",   {28'd0, bus.out_tag}, 32'h0);
        check("t1_checksum",  {16'd0, checksum}, {16'd0, exp_csum()});
        bus.out_ready = 1'b1;
        wait_empty();

        // Rotation uses round index; then state 2 and 3
        do_reset();
        bus.out_ready = 1'b1;
        send(2'd0, 16'h0000, 16'h0000, 16'h0000);
        send(2'd1, 16'h8001, 16'h5A5A, 16'h0006);
        send(2'd2, 16'hFFFF, 16'h0002, 16'h0001);
        send(2'd3, 16'h1234, 16'h00FF, 16'hCB12);
        wait_empty();
        check("t2_checksum", {16'd0, checksum}, {16'd0, exp_csum()});

        // Fill with stall, then saturate the stall counter
        do_reset();
        bus.out_ready = 1'b0;
        acc = 0;
        idx = 0;
        for (int c = 0; c < 270; c++) begin
            bus.in_valid = 1'b1;
            bus.in_state = 2'd0;
            bus.key      = 16'h0F0F;
            bus.in_data  = fill_in[idx];
            if (bus.in_ready) begin
                sb.push_back({fill_out[idx], 2'd0, exp_r});
                exp_r  = exp_r + 2'd1;
                csum_m = csum_m ^ fill_out[idx];
                idx++;
                acc++;
            end
            @(posedge clk);
            #1;
            if (c == 9) begin
                check("fill_accepts",   acc, 4);
                check("fill_in_ready",  {31'd0, bus.in_ready}, 32'd0);
                check("fill_stall_cnt", {24'd0, stall_cnt}, 32'd6);
            end
        end
        check("stall_saturate", {24'd0, stall_cnt}, 32'hFF);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_empty();
        check("fill_checksum", {16'd0, checksum}, {16'd0, exp_csum()});

        // Concurrent accept and drain at occupancy 2
        do_reset();
        bus.out_ready = 1'b0;
        send(2'd2, 16'hFFFF, 16'h0002, 16'h0001);
        send(2'd3, 16'h1234, 16'h00FF, 16'hCB12);
        bus.out_ready = 1'b1;
        d0 = drains;
        send(2'd0, 16'h0001, 16'hA5A5, 16'hA5A4);
        send(2'd0, 16'h0002, 16'hA5A5, 16'hA5A7);
        send(2'd0, 16'h0003, 16'hA5A5, 16'hA5A6);
        send(2'd0, 16'h0004, 16'hA5A5, 16'hA5A1);
        send(2'd0, 16'h0005, 16'hA5A5, 16'hA5A0);
        send(2'd0, 16'h0006, 16'hA5A5, 16'hA5A3);
        send(2'd0, 16'h0007, 16'hA5A5, 16'hA5A2);
        send(2'd0, 16'h0008, 16'hA5A5, 16'hA5AD);
        bus.out_ready = 1'b0;
        check("conc_drains",    drains - d0, 8);
        check("conc_head_data", {16'd0, bus.out_data}, 32'hA5A2);
        check("conc_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        check("conc_checksum",  {16'd0, checksum}, {16'd0, exp_csum()});
        bus.out_ready = 1'b1;
        cnt = 0;
        while (bus.out_valid && cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("conc_occupancy", cnt, 2);

        // Reset mid-operation
        bus.out_ready = 1'b0;
        send(2'd0, 16'h0101, 16'h0000, 16'h0101);
        send(2'd0, 16'h0202, 16'h0000, 16'h0202);
        send(2'd0, 16'h0303, 16'h0000, 16'h0303);
        check("mid_buffered", {31'd0, bus.out_valid}, 32'd1);
        do_reset();
        check("mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        check("mid_checksum",  {16'd0, checksum}, 32'd0);
        check("mid_stall_cnt", {24'd0, stall_cnt}, 32'd0);
        send(2'd1, 16'h8001, 16'h0000, 16'h0003);
        check("mid_tag_r0",  {28'd0, bus.out_tag}, 32'h4);
        check("mid_data",    {16'd0, bus.out_data}, 32'h0003);
        bus.out_ready = 1'b1;
        wait_empty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stage3_mixer.md
# stage3_mixer

Third pipeline stage of the crypto datapath. Consumes the 16-bit word and 2-bit FSM state produced by the stage-2 FSM, applies a state-selected keyed transform with a rotating round index, and buffers the results in a small FIFO. The FIFO is drained through a valid/ready interface toward the output stage. It also keeps a running XOR checksum and a saturating stall counter.

## Interface
- `DEPTH`, default 4: FIFO entries. Must be a power of 2, ≥2.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: upstream word present.
- `in_ready` out 1: stage can accept a word.
- `in_data` in 16: word from stage-2 `out_data`.
- `in_state` in 2: transform select, from stage-2 `state`.
- `key` in 16: round key, sampled on each accepted word.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream accepts the head.
- `out_data` out 16: transformed word at the FIFO head.
- `out_tag` out 4: `{state, round}` stored with the head word.
- `checksum` out 16: running XOR of every accepted transformed word.
- `stall_cnt` out 8: saturating count of stalled cycles.

## Operation
- **Accept:** `in_valid && in_ready` in a cycle. **Drain:** `out_valid && out_ready` in a cycle.
- **Round counter `r`:**
  - 2 bits, reset 0.
  - Increments by 1 on each accept; wraps from 3 to 0.
  - The current value of `r` is used for the word being accepted.
- **Transform `t`**, combinational on the accept cycle, all arithmetic mod 2^16:
  - state 0: `in_data ^ key`
  - state 1: rotate-left `in_data` by `r+1` bits (1..4)
  - state 2: `in_data + key`, carry dropped
  - state 3: `{in_data[7:0], in_data[15:8]} ^ ~key`
- **Write:** on accept, `{t, in_state, r}` is written at the write pointer, and the write pointer increments.
- **Read:** on drain, the read pointer increments.
- **Pointers:** `log2(DEPTH)+1` bits; the extra MSB distinguishes full from empty.
  - empty: pointers equal.
  - full: low bits equal and MSBs differ.
- **Ready/valid:**
  - `in_ready = !full`, combinational from registered pointers; it does not depend on `out_ready`.
  - `out_valid = !empty`.
  - `out_data` and `out_tag` come from a combinational read of the head entry and are don't-care when `out_valid=0`.
- **Checksum:** `checksum <= checksum ^ t` on each accept.
- **Stall counter:** `stall_cnt` increments in each cycle with `in_valid && !in_ready`. It saturates at 8'hFF.
- **Boundary conditions:**
  - Full, with a drain and `in_valid` in the same cycle: no accept that cycle. `in_ready` rises next cycle.
  - Empty: no drain. No bypass, so a word is never output in the cycle it is accepted.
  - Accept and drain in the same cycle, neither full nor empty: both happen and occupancy is unchanged.
  - Pointer wrap at DEPTH: the low bits wrap and the MSB toggles.
  - `in_state` is used exactly as given; no decoding error is possible.
- **Reset** (sync, any time, including mid-burst): all FIFO contents are discarded and every state register is restored.
  - After reset: `in_ready=1`, `out_valid=0`, `checksum=0`, `stall_cnt=0`, `r=0`.
  - `out_data=0` and `out_tag=0` because memory entry 0 is cleared.

## Timing
- Latency: an accept at edge N makes the word visible on `out_*` after edge N, and drainable at edge N+1 at the earliest.
- Throughput: one word per cycle sustained when `out_ready=1`.
- Handshake rule: `in_data`, `in_state` and `key` must be stable while `in_valid=1 && in_ready=0`. Upstream must hold `in_valid` until it is accepted.
- Counter updates:
  - `checksum` and `r` update at the accept edge.
  - `stall_cnt` updates at the edge that ends a stalled cycle.
- In the cycle with `rst=1`, no accept or drain takes effect.

## Configuration
- `STAGE3_CHECKSUM_EN`:
  - Defined: the checksum register and XOR logic are built, and `checksum` behaves as described above.
  - Not defined: no checksum register is instantiated, and `checksum` is tied to 16'h0000.
- All other behaviour is identical in both builds.
- The port list is identical in both builds.

## Test plan
- **Reset then single word:** `rst` 1 cycle; then `in_state=0`, `in_data=16'h1234`, `key=16'h00FF`.
  - Required: `out_data=16'h12CB`, `out_tag=4'b0000`, one cycle after accept.
  - Required: `checksum=16'h12CB` with the macro; `checksum=16'h0000` without it.
- **Rotation uses the round index:** first word any state; second word `in_state=1`, `in_data=16'h8001`.
  - Required: second output `16'h0006`, `out_tag=4'b0101`.
- **State 2 and state 3 transforms:**
  - state 2: `16'hFFFF`, `key=16'h0002` → `16'h0001`.
  - state 3: `16'h1234`, `key=16'h00FF` → `16'hCB12`.
- **Fill with stall:** `out_ready=0`, `in_valid=1` for 10 cycles with DEPTH=4.
  - Required: 4 accepts, then `in_ready=0`, and `stall_cnt=6`.
  - Then `out_ready=1`: words drain in order, with tags showing `r` wrapping 0,1,2,3.
- **Concurrent accept and drain:** occupancy 2, with `in_valid=1` and `out_ready=1` for 8 cycles.
  - Required: 8 accepts, 8 drains, and occupancy still 2.
- **Reset mid-operation:** 3 words buffered, then `rst` for 1 cycle.
  - Required: next cycle `out_valid=0`, `in_ready=1`, `checksum=0`, `stall_cnt=0`.
  - Required: the next accepted word is tagged `r=0`.
